// File: rtl/gt_link_pkg.sv
// Shared state encoding and counter-width helper for the GT/PCS link bring-up sequencer.
package gt_link_pkg;

  typedef enum logic [2:0] {
    WAIT_PLL  = 3'd0,
    TX_RST    = 3'd1,
    WAIT_TX   = 3'd2,
    RX_RST    = 3'd3,
    WAIT_RX   = 3'd4,
    WAIT_LOCK = 3'd5,
    LINK_UP   = 3'd6
  } state_t;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gt_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; resets to 0.
module gt_sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gt_link_ctrl.sv
// GT/PCS link sequencer: orders TX/RX/PCS resets against PLL lock, reset-done and block lock,
// reports link-up, retries on timeout and recovers the RX path on loss of block lock.
module gt_link_ctrl
  import gt_link_pkg::*;
#(
  parameter int RST_HOLD  = 16,
  parameter int TIMEOUT   = 100000,
  parameter int STABLE    = 1024,
  parameter int LOSS_FILT = 64,
  parameter int RETRY_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock_i,
  input  logic               tx_rst_done_i,
  input  logic               rx_rst_done_i,
  input  logic               block_lock_i,
  output logic               gt_tx_rst_o,
  output logic               gt_rx_rst_o,
  output logic               pcs_rst_o,
  output logic               link_up_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [2:0]         state_o
);

  localparam int CNT_W  = cnt_w((TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD);
  localparam int STB_W  = cnt_w(STABLE);
  localparam int LOSS_W = cnt_w(LOSS_FILT);

  logic w_pll_s, w_tx_done_s, w_rx_done_s, w_lock_s;

  gt_sync_2ff u_sync_pll  (.i_clk(clk), .i_rst(rst), .i_d(pll_lock_i),    .o_q(w_pll_s));
  gt_sync_2ff u_sync_txd  (.i_clk(clk), .i_rst(rst), .i_d(tx_rst_done_i), .o_q(w_tx_done_s));
  gt_sync_2ff u_sync_rxd  (.i_clk(clk), .i_rst(rst), .i_d(rx_rst_done_i), .o_q(w_rx_done_s));
  gt_sync_2ff u_sync_lock (.i_clk(clk), .i_rst(rst), .i_d(block_lock_i),  .o_q(w_lock_s));

  state_t              r_state, w_state_nxt;
  logic                w_retry_inc;
  logic [CNT_W-1:0]    r_cnt;
  logic [STB_W-1:0]    r_stable;
  logic [LOSS_W-1:0]   r_loss;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_tx_rst, r_rx_rst, r_pcs_rst, r_link_up;
  logic                w_tx_rst_d, w_rx_rst_d, w_pcs_rst_d, w_link_up_d;
  logic                w_hold_done, w_timeout, w_stable_hit, w_loss_hit;

  assign w_hold_done  = (r_cnt == CNT_W'(RST_HOLD - 1));
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_stable_hit = w_lock_s && (r_stable == STB_W'(STABLE - 1));
  assign w_loss_hit   = !w_lock_s && (r_loss == LOSS_W'(LOSS_FILT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_PLL;
    else     r_state <= w_state_nxt;
  end

  // PLL loss overrides everything; within a state, progress is tested before timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    if (r_state != WAIT_PLL && !w_pll_s) begin
      w_state_nxt = WAIT_PLL;
    end else begin
      case (r_state)
        WAIT_PLL:  if (w_pll_s) w_state_nxt = TX_RST;
        TX_RST:    if (w_hold_done) w_state_nxt = WAIT_TX;
        WAIT_TX: begin
          if (w_tx_done_s)    w_state_nxt = RX_RST;
          else if (w_timeout) begin w_state_nxt = TX_RST; w_retry_inc = 1'b1; end
        end
        RX_RST:    if (w_hold_done) w_state_nxt = WAIT_RX;
        WAIT_RX: begin
          if (w_rx_done_s)    w_state_nxt = WAIT_LOCK;
          else if (w_timeout) begin w_state_nxt = TX_RST; w_retry_inc = 1'b1; end
        end
        WAIT_LOCK: begin
          if (w_stable_hit)   w_state_nxt = LINK_UP;
          else if (w_timeout) begin w_state_nxt = TX_RST; w_retry_inc = 1'b1; end
        end
        LINK_UP:   if (w_loss_hit) begin w_state_nxt = RX_RST; w_retry_inc = 1'b1; end
        default:   w_state_nxt = WAIT_PLL;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_comb begin
    w_tx_rst_d  = 1'b0;
    w_rx_rst_d  = 1'b0;
    w_pcs_rst_d = 1'b0;
    w_link_up_d = 1'b0;
    case (w_state_nxt)
      WAIT_PLL, TX_RST: begin w_tx_rst_d = 1'b1; w_rx_rst_d = 1'b1; w_pcs_rst_d = 1'b1; end
      WAIT_TX, RX_RST:  begin w_rx_rst_d = 1'b1; w_pcs_rst_d = 1'b1; end
      WAIT_RX:          w_pcs_rst_d = 1'b1;
      WAIT_LOCK:        begin end
      LINK_UP:          w_link_up_d = 1'b1;
      default:          begin w_tx_rst_d = 1'b1; w_rx_rst_d = 1'b1; w_pcs_rst_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_rst  <= 1'b1;
      r_rx_rst  <= 1'b1;
      r_pcs_rst <= 1'b1;
      r_link_up <= 1'b0;
      r_retry   <= '0;
    end else begin
      r_tx_rst  <= w_tx_rst_d;
      r_rx_rst  <= w_rx_rst_d;
      r_pcs_rst <= w_pcs_rst_d;
      r_link_up <= w_link_up_d;
      if (w_retry_inc && r_retry != '1) r_retry <= r_retry + RETRY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= '0;
      r_loss   <= '0;
    end else begin
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != '1)       r_cnt <= r_cnt + CNT_W'(1);
      if (r_state != WAIT_LOCK || !w_lock_s) r_stable <= '0;
      else if (r_stable != '1)               r_stable <= r_stable + STB_W'(1);
      if (r_state != LINK_UP || w_lock_s) r_loss <= '0;
      else if (r_loss != '1)              r_loss <= r_loss + LOSS_W'(1);
    end
  end

  assign gt_tx_rst_o = r_tx_rst;
  assign gt_rx_rst_o = r_rx_rst;
  assign pcs_rst_o   = r_pcs_rst;
  assign link_up_o   = r_link_up;
  assign retry_cnt_o = r_retry;
  assign state_o     = r_state;

endmodule

// File: tb/tb_gt_link_ctrl.sv
// Scenario bench for gt_link_ctrl: expected state transitions are queued per scenario and
// popped as the DUT changes state; a second instance with a 2-bit retry counter covers saturation.
module tb_gt_link_ctrl;
  import gt_link_pkg::*;

  localparam int RST_HOLD  = 4;
  localparam int TIMEOUT   = 50;
  localparam int STABLE    = 8;
  localparam int LOSS_FILT = 4;

  logic       clk, rst;
  logic       pll, txd, rxd, blk;
  logic       tx_rst, rx_rst, pcs_rst, lu;
  logic [7:0] retry;
  logic [2:0] st;
  logic       tx_rst2, rx_rst2, pcs_rst2, lu2;
  logic [1:0] retry2;
  logic [2:0] st2;
  logic [3:0] obs_outs;

  assign obs_outs = {tx_rst, rx_rst, pcs_rst, lu};

  gt_link_ctrl #(.RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT), .STABLE(STABLE),
                 .LOSS_FILT(LOSS_FILT), .RETRY_W(8)) dut (
    .clk(clk), .rst(rst), .pll_lock_i(pll), .tx_rst_done_i(txd), .rx_rst_done_i(rxd),
    .block_lock_i(blk), .gt_tx_rst_o(tx_rst), .gt_rx_rst_o(rx_rst), .pcs_rst_o(pcs_rst),
    .link_up_o(lu), .retry_cnt_o(retry), .state_o(st)
  );

  gt_link_ctrl #(.RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT), .STABLE(STABLE),
                 .LOSS_FILT(LOSS_FILT), .RETRY_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pll_lock_i(pll), .tx_rst_done_i(txd), .rx_rst_done_i(rxd),
    .block_lock_i(blk), .gt_tx_rst_o(tx_rst2), .gt_rx_rst_o(rx_rst2), .pcs_rst_o(pcs_rst2),
    .link_up_o(lu2), .retry_cnt_o(retry2), .state_o(st2)
  );

  typedef struct {
    logic [2:0] st;
    int         n;
    logic [3:0] outs;
    int         rc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; pll = 1'b0; txd = 1'b0; rxd = 1'b0; blk = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Waits for the next state change; s=7 and n=200 mean it never came.
  task automatic wait_change(output logic [2:0] s, output int n, output bit saw_lu);
    logic [2:0] s0;
    s0 = st; s = 3'd7; n = 0; saw_lu = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      saw_lu |= lu;
      if (st != s0) begin
        s = st;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pll = 1'b0; txd = 1'b0; rxd = 1'b0; blk = 1'b0;
    step(1);
    n_chk++;
    if (st !== 3'd0 || obs_outs !== 4'b1110 || retry !== 8'd0 || retry2 !== 2'd0) begin
      n_err++;
      $display("FAIL reset_values: state=%0d outs=%b retry=%0d/%0d, expected state=0 outs=1110 retry=0/0",
               st, obs_outs, retry, retry2);
    end
    rst = 1'b0;
    step(10);
    n_chk++;
    if (st !== 3'd0 || obs_outs !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_no_pll: state=%0d outs=%b, expected state=0 outs=1110", st, obs_outs);
    end
  endtask

  task automatic test_bringup();
    exp_t e; logic [2:0] s; int n; bit sl;
    apply_reset();
    pll = 1'b1; blk = 1'b1;
    q.delete();
    q.push_back('{st: TX_RST,    n: 3, outs: 4'b1110, rc: 0});
    q.push_back('{st: WAIT_TX,   n: 4, outs: 4'b0110, rc: 0});
    q.push_back('{st: RX_RST,    n: 3, outs: 4'b0110, rc: 0});
    q.push_back('{st: WAIT_RX,   n: 4, outs: 4'b0010, rc: 0});
    q.push_back('{st: WAIT_LOCK, n: 3, outs: 4'b0000, rc: 0});
    q.push_back('{st: LINK_UP,   n: STABLE, outs: 4'b0001, rc: 0});
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin step(5); txd = 1'b1; end
      if (i == 4) begin step(5); rxd = 1'b1; end
      e = q.pop_front();
      wait_change(s, n, sl);
      n_chk++;
      if (s !== e.st || n != e.n || obs_outs !== e.outs || retry !== 8'(e.rc)) begin
        n_err++;
        $display("FAIL bringup_step%0d: state=%0d dt=%0d outs=%b retry=%0d, expected state=%0d dt=%0d outs=%b retry=%0d",
                 i, s, n, obs_outs, retry, e.st, e.n, e.outs, e.rc);
      end
    end
  endtask

  task automatic test_tx_timeout();
    exp_t e; logic [2:0] s; int n; bit sl;
    apply_reset();
    pll = 1'b1;
    q.delete();
    q.push_back('{st: TX_RST, n: 3, outs: 4'b1110, rc: 0});
    for (int k = 1; k <= 3; k++) begin
      q.push_back('{st: WAIT_TX, n: RST_HOLD, outs: 4'b0110, rc: k - 1});
      q.push_back('{st: TX_RST,  n: TIMEOUT,  outs: 4'b1110, rc: k});
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_change(s, n, sl);
      n_chk++;
      if (s !== e.st || n != e.n || obs_outs !== e.outs || retry !== 8'(e.rc)) begin
        n_err++;
        $display("FAIL tx_timeout: state=%0d dt=%0d outs=%b retry=%0d, expected state=%0d dt=%0d outs=%b retry=%0d",
                 s, n, obs_outs, retry, e.st, e.n, e.outs, e.rc);
      end
    end
  endtask

  task automatic test_lock_chatter();
    exp_t e; logic [2:0] s; int n; bit sl; bit any_lu;
    apply_reset();
    pll = 1'b1; txd = 1'b1; rxd = 1'b1;
    q.delete();
    q.push_back('{st: TX_RST,    n: 3,        outs: 4'b1110, rc: 0});
    q.push_back('{st: WAIT_TX,   n: RST_HOLD, outs: 4'b0110, rc: 0});
    q.push_back('{st: RX_RST,    n: 1,        outs: 4'b0110, rc: 0});
    q.push_back('{st: WAIT_RX,   n: RST_HOLD, outs: 4'b0010, rc: 0});
    q.push_back('{st: WAIT_LOCK, n: 1,        outs: 4'b0000, rc: 0});
    q.push_back('{st: TX_RST,    n: TIMEOUT,  outs: 4'b1110, rc: 1});
    any_lu = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          blk = ((i % 8) != 7);
          @(negedge clk);
        end
      end
      begin
        while (q.size() > 0) begin
          e = q.pop_front();
          wait_change(s, n, sl);
          any_lu |= sl;
          n_chk++;
          if (s !== e.st || n != e.n || obs_outs !== e.outs || retry !== 8'(e.rc)) begin
            n_err++;
            $display("FAIL lock_chatter: state=%0d dt=%0d outs=%b retry=%0d, expected state=%0d dt=%0d outs=%b retry=%0d",
                     s, n, obs_outs, retry, e.st, e.n, e.outs, e.rc);
          end
        end
      end
    join
    n_chk++;
    if (any_lu !== 1'b0) begin
      n_err++;
      $display("FAIL lock_chatter_no_linkup: link_up seen=%0b, expected 0", any_lu);
    end
  endtask

  task automatic test_loss();
    exp_t e; logic [2:0] s; int n; bit sl; bit ok; bit up_ok;
    apply_reset();
    pll = 1'b1; txd = 1'b1; rxd = 1'b1; blk = 1'b1;
    wait_state(LINK_UP, 100, ok);
    n_chk++;
    if (!ok || lu !== 1'b1) begin
      n_err++;
      $display("FAIL loss_reach_linkup: reached=%0b link_up=%0b, expected 1/1", ok, lu);
    end
    up_ok = 1'b1;
    blk = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == LOSS_FILT - 1) blk = 1'b1;
      @(negedge clk);
      if (lu !== 1'b1 || st !== 3'(LINK_UP)) up_ok = 1'b0;
    end
    n_chk++;
    if (!up_ok || retry !== 8'd0) begin
      n_err++;
      $display("FAIL loss_short_dip: link held=%0b retry=%0d, expected 1 and 0", up_ok, retry);
    end
    q.delete();
    q.push_back('{st: RX_RST, n: 2 + LOSS_FILT, outs: 4'b0110, rc: 1});
    blk = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_change(s, n, sl);
      n_chk++;
      if (s !== e.st || n != e.n || obs_outs !== e.outs || retry !== 8'(e.rc)) begin
        n_err++;
        $display("FAIL loss_recover: state=%0d dt=%0d outs=%b retry=%0d, expected state=%0d dt=%0d outs=%b retry=%0d",
                 s, n, obs_outs, retry, e.st, e.n, e.outs, e.rc);
      end
    end
  endtask

  task automatic test_pll_loss();
    exp_t e; logic [2:0] s; int n; bit sl; bit ok;
    apply_reset();
    pll = 1'b1; blk = 1'b1;
    for (int i = 0; i < 200 && retry != 8'd1; i++) @(negedge clk);
    txd = 1'b1;
    wait_state(WAIT_RX, 100, ok);
    n_chk++;
    if (!ok || retry !== 8'd1) begin
      n_err++;
      $display("FAIL pll_reach_wait_rx: reached=%0b retry=%0d, expected 1/1", ok, retry);
    end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        pll = 1'b1; rxd = 1'b1;
        wait_state(LINK_UP, 200, ok);
        n_chk++;
        if (!ok) begin
          n_err++;
          $display("FAIL pll_reach_linkup: reached=%0b, expected 1", ok);
        end
      end
      q.delete();
      q.push_back('{st: WAIT_PLL, n: 3, outs: 4'b1110, rc: 1});
      pll = 1'b0;
      while (q.size() > 0) begin
        e = q.pop_front();
        wait_change(s, n, sl);
        n_chk++;
        if (s !== e.st || n != e.n || obs_outs !== e.outs || retry !== 8'(e.rc)) begin
          n_err++;
          $display("FAIL pll_loss_pass%0d: state=%0d dt=%0d outs=%b retry=%0d, expected state=%0d dt=%0d outs=%b retry=%0d",
                   pass, s, n, obs_outs, retry, e.st, e.n, e.outs, e.rc);
        end
      end
    end
  endtask

  task automatic test_async_reset_and_saturation();
    bit ok;
    apply_reset();
    pll = 1'b1; txd = 1'b1; rxd = 1'b1; blk = 1'b0;
    wait_state(WAIT_LOCK, 100, ok);
    n_chk++;
    if (!ok || obs_outs !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reach_wait_lock: reached=%0b outs=%b, expected 1 and 0000", ok, obs_outs);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (st !== 3'd0 || obs_outs !== 4'b1110 || retry !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset: state=%0d outs=%b retry=%0d, expected state=0 outs=1110 retry=0",
               st, obs_outs, retry);
    end
    @(negedge clk);
    txd = 1'b0;
    rst = 1'b0;
    step(170);
    n_chk++;
    if (retry !== 8'd3 || retry2 !== 2'd3) begin
      n_err++;
      $display("FAIL sat_three: retry=%0d retry_w2=%0d, expected 3 and 3", retry, retry2);
    end
    step(110);
    n_chk++;
    if (retry !== 8'd5 || retry2 !== 2'd3) begin
      n_err++;
      $display("FAIL sat_five: retry=%0d retry_w2=%0d, expected 5 and 3", retry, retry2);
    end
  endtask

  initial begin
    rst = 1'b1; pll = 1'b0; txd = 1'b0; rxd = 1'b0; blk = 1'b0;
    test_reset();
    test_bringup();
    test_tx_timeout();
    test_lock_chatter();
    test_loss();
    test_pll_loss();
    test_async_reset_and_saturation();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
